clk_pulse_gen_multi: RTL and testbench

//   Multi-channel clock-enable pulse generator. It produces glitch-free, registered enable pulses for

---
 rtl/clk_pulse_gen_multi.sv | 143 ++++++++++++++
 tb/tb_clk_pulse_gen_multi.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_pulse_gen_multi.sv
// Multi-channel clock-enable pulse generator: per-channel period/width/mode with
// shadow config that only takes effect at period start, registered pulse outputs.

module clk_pulse_chan #(
    parameter int CNT_W = 8
) (
    input  logic             CP,
    input  logic             _MR,
    input  logic             cfg_wr,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_burst,
    input  logic             en_n,
    output logic             pulse,
    output logic             busy,
    output logic             done
);
    typedef struct packed {
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] wid;
        logic [1:0]       mode;
        logic [CNT_W-1:0] burst;
    } cfg_t;

    localparam cfg_t CFG_RST = '{per: CNT_W'(1), wid: CNT_W'(1), mode: 2'd0, burst: CNT_W'(1)};

    cfg_t             shd_q, shd_d, act_q, act_d;
    logic             run_q, run_d, armed_q, armed_d, pulse_q, pulse_d, done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, bcnt_q, bcnt_d;
    logic             end_per, leave;

    always_comb begin
        shd_d   = shd_q;
        act_d   = act_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        pulse_d = pulse_q;
        done_d  = 1'b0;
        armed_d = armed_q | en_n;
        end_per = (cnt_q == act_q.per - CNT_W'(1));
        case (act_q.mode)
            2'd1:    leave = 1'b1;
            2'd2:    leave = (bcnt_q == act_q.burst - CNT_W'(1));
            default: leave = en_n;
        endcase

        // zero period / burst are folded to 1 on write so the counters never see 0
        if (cfg_wr) begin
            shd_d.per   = (cfg_period == '0) ? CNT_W'(1) : cfg_period;
            shd_d.wid   = cfg_width;
            shd_d.mode  = cfg_mode;
            shd_d.burst = (cfg_burst == '0) ? CNT_W'(1) : cfg_burst;
        end

        if (!run_q) begin
            if (!en_n && armed_q) begin
                run_d   = 1'b1;
                act_d   = shd_q;
                cnt_d   = '0;
                bcnt_d  = '0;
                pulse_d = (shd_q.wid != '0);
            end
        end else if (end_per && leave) begin
            run_d   = 1'b0;
            cnt_d   = '0;
            pulse_d = 1'b0;
            done_d  = 1'b1;
            if (act_q.mode == 2'd1) armed_d = 1'b0;
        end else if (end_per) begin
            act_d   = shd_q;
            cnt_d   = '0;
            bcnt_d  = bcnt_q + CNT_W'(1);
            pulse_d = (shd_q.wid != '0);
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            pulse_d = ((cnt_q + CNT_W'(1)) < act_q.wid);
        end
    end

    always_ff @(posedge CP or negedge _MR) begin
        if (!_MR) begin
            shd_q   <= CFG_RST;
            act_q   <= CFG_RST;
            run_q   <= 1'b0;
            armed_q <= 1'b1;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            shd_q   <= shd_d;
            act_q   <= act_d;
            run_q   <= run_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
        end
    end

    assign pulse = pulse_q;
    assign busy  = run_q;
    assign done  = done_q;
endmodule

module clk_pulse_gen_multi #(
    parameter  int CHANNELS = 4,
    parameter  int CNT_W    = 8,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CP,
    input  logic                _MR,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [CNT_W-1:0]    cfg_width,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_burst,
    input  logic [CHANNELS-1:0] _en,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);
    // a select beyond CHANNELS-1 matches no instance and is dropped
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        clk_pulse_chan #(.CNT_W(CNT_W)) u_ch (
            .CP         (CP),
            ._MR        (_MR),
            .cfg_wr     (cfg_we && (cfg_ch == CH_W'(i))),
            .cfg_period (cfg_period),
            .cfg_width  (cfg_width),
            .cfg_mode   (cfg_mode),
            .cfg_burst  (cfg_burst),
            .en_n       (_en[i]),
            .pulse      (pulse[i]),
            .busy       (busy[i]),
            .done       (done[i])
        );
    end
endmodule

// File: tb/tb_clk_pulse_gen_multi.sv
// Scoreboard bench for clk_pulse_gen_multi: a period-waveform reference model
// queues expected outputs per edge; a monitor pops and compares after each edge.

module tb_clk_pulse_gen_multi;
    localparam int NCH   = 3;
    localparam int CNT_W = 8;
    localparam int CHW   = 2;

    logic             CP;
    logic             mr_n;
    logic             cfg_we;
    logic [CHW-1:0]   cfg_ch;
    logic [CNT_W-1:0] cfg_period, cfg_width, cfg_burst;
    logic [1:0]       cfg_mode;
    logic [NCH-1:0]   en_n;
    logic [NCH-1:0]   pulse, busy, done;

    clk_pulse_gen_multi #(.CHANNELS(NCH), .CNT_W(CNT_W)) dut (
        .CP(CP), ._MR(mr_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_width(cfg_width), .cfg_mode(cfg_mode),
        .cfg_burst(cfg_burst), ._en(en_n), .pulse(pulse), .busy(busy), .done(done)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    typedef struct packed {
        logic [NCH-1:0] p;
        logic [NCH-1:0] b;
        logic [NCH-1:0] d;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: each period is expanded into its full pulse waveform up front
    int sh_p[NCH], sh_w[NCH], sh_m[NCH], sh_b[NCH];
    int ac_m[NCH], ac_b[NCH];
    bit run[NCH], armed[NCH];
    int nper[NCH];
    bit perq[NCH][$];

    task automatic chk(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            sh_p[c] = 1; sh_w[c] = 1; sh_m[c] = 0; sh_b[c] = 1;
            ac_m[c] = 0; ac_b[c] = 1;
            run[c] = 0; armed[c] = 1; nper[c] = 0;
            perq[c].delete();
        end
        expq.delete();
    endfunction

    function automatic void new_period(input int c);
        ac_m[c] = sh_m[c];
        ac_b[c] = sh_b[c];
        perq[c].delete();
        for (int i = 0; i < sh_p[c]; i++) perq[c].push_back(i < sh_w[c]);
    endfunction

    function automatic void model_step(input logic [NCH-1:0] en, input bit we, input int ch,
                                       input int p, input int w, input int m, input int b);
        exp_t e;
        bit   a_old, ex;
        e = '0;
        for (int c = 0; c < NCH; c++) begin
            a_old = armed[c];
            armed[c] = armed[c] | en[c];
            if (!run[c]) begin
                if (!en[c] && a_old) begin
                    new_period(c);
                    run[c] = 1;
                    nper[c] = 1;
                end
            end else if (perq[c].size() == 0) begin
                case (ac_m[c])
                    1:       ex = 1;
                    2:       ex = (((nper[c] - 1) % (1 << CNT_W)) == ac_b[c] - 1);
                    default: ex = en[c];
                endcase
                if (ex) begin
                    run[c] = 0;
                    e.d[c] = 1'b1;
                    if (ac_m[c] == 1) armed[c] = 0;
                end else begin
                    new_period(c);
                    nper[c]++;
                end
            end
            if (run[c]) begin
                e.p[c] = perq[c].pop_front();
                e.b[c] = 1'b1;
            end
        end
        if (we && ch < NCH) begin
            sh_p[ch] = (p == 0) ? 1 : p;
            sh_w[ch] = w;
            sh_m[ch] = m;
            sh_b[ch] = (b == 0) ? 1 : b;
        end
        expq.push_back(e);
    endfunction

    task automatic cyc(input logic [NCH-1:0] en, input bit we, input int ch,
                       input int p, input int w, input int m, input int b);
        @(negedge CP);
        en_n       = en;
        cfg_we     = we;
        cfg_ch     = CHW'(ch);
        cfg_period = CNT_W'(p);
        cfg_width  = CNT_W'(w);
        cfg_mode   = 2'(m);
        cfg_burst  = CNT_W'(b);
        model_step(en, we, ch, p, w, m, b);
    endtask

    task automatic run_n(input int n, input logic [NCH-1:0] en);
        for (int i = 0; i < n; i++) cyc(en, 1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int ch, input int p, input int w, input int m, input int b,
                      input logic [NCH-1:0] en);
        cyc(en, 1'b1, ch, p, w, m, b);
    endtask

    // monitor: outputs are presented every edge once out of reset
    initial begin
        exp_t e;
        forever begin
            @(posedge CP);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("pulse", pulse, e.p);
                chk("busy", busy, e.b);
                chk("done", done, e.d);
            end
        end
    end

    initial begin
        logic [NCH-1:0] en_r;
        mr_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_width = '0;
        cfg_mode = '0; cfg_burst = '0; en_n = '1;
        model_reset();
        #3;
        chk("rst_pulse", pulse, '0);
        chk("rst_busy", busy, '0);
        chk("rst_done", done, '0);
        @(negedge CP); @(negedge CP);
        mr_n = 1'b1;
        run_n(3, 3'b111);

        // reset mid-pulse
        wr(0, 4, 2, 0, 1, 3'b111);
        run_n(2, 3'b110);
        @(posedge CP); #3;
        mr_n = 1'b0;
        #1;
        chk("midrst_pulse", pulse, '0);
        chk("midrst_busy", busy, '0);
        model_reset();
        @(negedge CP); @(negedge CP);
        mr_n = 1'b1;
        en_n = '1;
        run_n(4, 3'b111);

        // continuous, then release after a full stretch
        wr(0, 4, 1, 0, 1, 3'b111);
        run_n(8, 3'b110);
        run_n(2, 3'b110);
        run_n(6, 3'b111);

        // one-shot with re-arm
        wr(1, 3, 2, 1, 1, 3'b111);
        run_n(6, 3'b101);
        run_n(1, 3'b111);
        run_n(6, 3'b101);
        run_n(2, 3'b111);

        // burst not aborted by _en release
        wr(2, 2, 1, 2, 3, 3'b111);
        run_n(1, 3'b011);
        run_n(8, 3'b111);

        // config timing: mid-period write, then a write landing on the wrap edge
        wr(0, 4, 1, 0, 1, 3'b111);
        run_n(2, 3'b110);
        wr(0, 2, 1, 0, 1, 3'b110);
        run_n(7, 3'b110);
        wr(0, 4, 1, 0, 1, 3'b110);
        run_n(10, 3'b110);
        run_n(6, 3'b111);

        // boundaries
        wr(0, 3, 0, 0, 1, 3'b111);
        run_n(5, 3'b110);
        run_n(4, 3'b111);
        wr(0, 3, 5, 0, 1, 3'b111);
        run_n(7, 3'b110);
        run_n(4, 3'b111);
        wr(0, 0, 1, 0, 0, 3'b111);
        run_n(4, 3'b110);
        run_n(3, 3'b111);
        wr(3, 7, 7, 2, 7, 3'b111);
        wr(1, 3, 1, 0, 1, 3'b111);
        run_n(8, 3'b000);
        run_n(8, 3'b111);

        // randomized traffic
        en_r = '1;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 5) == 0) en_r[$urandom_range(0, NCH - 1)] ^= 1'b1;
            if ($urandom_range(0, 4) == 0)
                wr($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 7),
                   $urandom_range(0, 3), $urandom_range(0, 4), en_r);
            else
                run_n(1, en_r);
        end
        run_n(4, 3'b111);

        @(posedge CP); #4;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
